// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared defaults and index helpers for the register-bank write arbiter.
// Pure declarations: no latency, no flow control.
package reg_bank_pkg;
    localparam int DEF_NREQ = 4;
    localparam int DEF_NREG = 4;
    localparam int DEF_DW   = 4;

    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

    // k-th position of a circular priority scan that starts at base
    function automatic int unsigned rr_index(input int unsigned base, input int unsigned k,
                                             input int unsigned n);
        return (base + k) % n;
    endfunction

    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 == n) ? 32'd0 : idx + 32'd1;
    endfunction
endpackage

// File: rtl/reg_bank_write_arbiter_rr_arbiter.sv
// Round-robin pick of the first eligible requester at or after the pointer.
// Purely combinational (0 cycles); the caller applies stall/backpressure.
module rr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [PW-1:0]   i_ptr,
    output logic [PW-1:0]   o_win,
    output logic            o_vld
);
    always_comb begin
        o_win = '0;
        o_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_vld && i_elig[rr_index(32'(i_ptr), k, NREQ)]) begin
                o_vld = 1'b1;
                o_win = PW'(rr_index(32'(i_ptr), k, NREQ));
            end
        end
    end
endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin share of one write port into an NREG register bank; all outputs registered, 1 cycle req->gnt/load.
// stall=1 or nothing eligible issues no grant; requesters hold req until their gnt pulse.
module reg_bank_write_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NREG = DEF_NREG,
    parameter int DW   = DEF_DW,
    parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               stall,
    output logic [NREQ-1:0]    gnt,
    output logic [NREG-1:0]    load,
    output logic [DW-1:0]      wdata,
    output logic               addr_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [NREG-1:0] r_load;
    logic [DW-1:0]   r_wdata;
    logic            r_addr_err;

    logic [NREQ-1:0] w_elig;
    logic [PW-1:0]   w_win;
    logic            w_vld;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_addr_ok;

    // Last cycle's grantee is masked so a held req cannot win twice in a row
    assign w_elig = req & ~r_gnt;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_win  (w_win),
        .o_vld  (w_vld)
    );

    assign w_addr    = req_addr[int'(w_win) * AW +: AW];
    assign w_data    = req_data[int'(w_win) * DW +: DW];
    assign w_addr_ok = ({1'b0, w_addr} < (AW + 1)'(NREG));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_load     <= '0;
            r_wdata    <= '0;
            r_addr_err <= 1'b0;
        end else if (!stall && w_vld) begin
            r_ptr      <= PW'(next_ptr(32'(w_win), NREQ));
            r_gnt      <= NREQ'(onehot(32'(w_win)));
            r_wdata    <= w_data;
            r_load     <= w_addr_ok ? NREG'(onehot(32'(w_addr))) : '0;
            r_addr_err <= ~w_addr_ok;
        end else begin
            r_gnt      <= '0;
            r_load     <= '0;
            r_addr_err <= 1'b0;
        end
    end

    assign gnt      = r_gnt;
    assign load     = r_load;
    assign wdata    = r_wdata;
    assign addr_err = r_addr_err;
endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Bench: two arbiters (NREG=4 and NREG=3) on shared stimulus, checked against a rule-level model.
module tb_reg_bank_write_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int AW   = 2;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               stall;

    logic [NREQ-1:0] gnt4, gnt3;
    logic [3:0]      load4;
    logic [2:0]      load3;
    logic [DW-1:0]   wdata4, wdata3;
    logic            err4, err3;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_bank_write_arbiter #(.NREQ(NREQ), .NREG(4), .DW(DW), .AW(AW)) dut4 (
        .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .req_data(req_data),
        .stall(stall), .gnt(gnt4), .load(load4), .wdata(wdata4), .addr_err(err4)
    );

    reg_bank_write_arbiter #(.NREQ(NREQ), .NREG(3), .DW(DW), .AW(AW)) dut3 (
        .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .req_data(req_data),
        .stall(stall), .gnt(gnt3), .load(load3), .wdata(wdata3), .addr_err(err3)
    );

    // Downstream bank fed by the NREG=4 arbiter
    logic [DW-1:0] bank4 [4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (load4[i]) bank4[i] <= wdata4;
    end

    // Model: build the circular scan order and take the first requester wanting a write
    // that was not granted last cycle.
    function automatic int pick(input logic [NREQ-1:0] r, input int ptr, input int last,
                                input logic st);
        int order[$];
        if (st) return -1;
        for (int k = 0; k < NREQ; k++) order.push_back((ptr + k) % NREQ);
        foreach (order[j]) if (r[order[j]] && order[j] != last) return order[j];
        return -1;
    endfunction

    int            m_ptr, m_last, m_pick, m_idx, m_addr;
    logic [3:0]    e_gnt, e_load4;
    logic [2:0]    e_load3;
    logic [DW-1:0] e_wdata, m_data;
    logic          e_err3;

    always_comb begin
        m_pick = pick(req, m_ptr, m_last, stall);
        m_idx  = (m_pick < 0) ? 0 : m_pick;
        m_addr = int'(req_addr[m_idx * AW +: AW]);
        m_data = req_data[m_idx * DW +: DW];
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ptr <= 0; m_last <= -1;
            e_gnt <= '0; e_load4 <= '0; e_load3 <= '0; e_wdata <= '0; e_err3 <= 1'b0;
        end else if (m_pick < 0) begin
            m_last <= -1;
            e_gnt <= '0; e_load4 <= '0; e_load3 <= '0; e_err3 <= 1'b0;
        end else begin
            m_last  <= m_pick;
            m_ptr   <= (m_pick + 1) % NREQ;
            e_gnt   <= 4'(1 << m_pick);
            e_wdata <= m_data;
            e_load4 <= 4'(1 << m_addr);
            e_load3 <= (m_addr < 3) ? 3'(1 << m_addr) : 3'b000;
            e_err3  <= (m_addr >= 3);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("model_dut4", 32'({gnt4, load4, wdata4, err4}), 32'({e_gnt, e_load4, e_wdata, 1'b0}));
            check("model_dut3", 32'({gnt3, load3, wdata3, err3}), 32'({e_gnt, e_load3, e_wdata, e_err3}));
        end
    endtask

    task automatic set_req(input int i, input int a, input int d);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = DW'(d);
    endtask

    logic [3:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        rstn = 1'b1; req = '0; req_addr = '0; req_data = '0; stall = 1'b0;
        #2 rstn = 1'b0;
        chk_en = 1'b1;
        tick();
        check("reset_out4", 32'({gnt4, load4, wdata4, err4}), 32'd0);
        check("reset_out3", 32'({gnt3, load3, wdata3, err3}), 32'd0);
        rstn = 1'b1;
        tick();

        // Round robin with each requester dropping after its grant
        for (int i = 0; i < NREQ; i++) set_req(i, i, i + 1);
        for (int k = 0; k < NREQ; k++) begin
            tick();
            check("rr_gnt", 32'(gnt4), 32'(rr_exp[k]));
            check("rr_model", 32'(e_gnt), 32'(rr_exp[k]));
            check("rr_wdata", 32'(wdata4), 32'(k + 1));
            req = req & ~gnt4;
        end

        // Two writes to register 2 in the same cycle serialize
        set_req(0, 2, 'hA);
        set_req(1, 2, 'h5);
        tick();
        check("coll_first", 32'({gnt4, load4, wdata4}), 32'({4'b0001, 4'b0100, 4'hA}));
        req[0] = 1'b0;
        tick();
        check("coll_second", 32'({gnt4, load4, wdata4}), 32'({4'b0010, 4'b0100, 4'h5}));
        req[1] = 1'b0;
        tick();
        check("coll_bank2", 32'(bank4[2]), 32'h5);

        // Stall blocks grants
        stall = 1'b1;
        set_req(1, 1, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_gnt", 32'(gnt4), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("stall_release", 32'(gnt4), 32'b0010);
        req[1] = 1'b0;

        // A held req is granted every other cycle
        set_req(0, 0, 6);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("repeat_mask", 32'(gnt4[0]), 32'(k % 2 == 0));
        end
        req = '0;
        tick();

        // Out-of-range address on the 3-register instance
        set_req(2, 3, 7);
        tick();
        check("bad_gnt", 32'(gnt3), 32'b0100);
        check("bad_load", 32'(load3), 32'd0);
        check("bad_err", 32'(err3), 32'd1);
        check("bad_wdata", 32'(wdata3), 32'd7);
        check("bad_load4", 32'({load4, err4}), 32'({4'b1000, 1'b0}));
        req = '0;
        tick();
        check("bad_err_pulse", 32'(err3), 32'd0);

        // Reset in the middle of a pending load
        set_req(0, 2, 9);
        tick();
        check("pre_reset_load", 32'(load4), 32'b0100);
        #2 rstn = 1'b0;
        #1;
        check("async_reset", 32'({gnt4, load4, wdata4, err4, gnt3, load3, err3}), 32'd0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, i, 12 + i);
        tick();
        check("post_reset_gnt", 32'(gnt4), 32'b0001);

        // Randomized traffic obeying the hold-until-grant contract
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt4[i] || !req[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                    else
                        req[i] = 1'b0;
                end
            end
            stall = ($urandom_range(0, 5) == 0);
            tick();
        end
        req = '0;
        stall = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
